// File: rtl/ps2_tx.sv
`timescale 1ns/1ps
// ps2_tx: host-to-device PS/2 transmitter.
// Sends one command byte to a keyboard or mouse. The host pulls ps2c low to
// request to send, then presents start, eight data bits (LSB first), odd
// parity and stop. Each bit changes after a falling edge of the
// device-generated clock. The host then samples the device ACK.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high
//   wr_ps2       start request, only sampled while idle
//   din          byte to send, latched when wr_ps2 is accepted
//   ps2d, ps2c   open-collector PS/2 data/clock, driven 0 or released (Z)
//   tx_idle      high only while the FSM is idle; feeds the receiver's rx_en
//   tx_done_tick one-clock pulse when the transaction completes
//   ack_err      high when the device did not ACK the last byte
module ps2_tx #(
  parameter int RTS_CYCLES = 8191
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2d,
  inout  wire        ps2c,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       ack_err
);

  localparam int CW = $clog2(RTS_CYCLES) + 1;

  typedef enum logic [2:0] {
    IDLE,
    RTS,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state_q;
  logic [7:0]    filter_q, filter_d;
  logic          f_ps2c_q, f_ps2c_d;
  logic          fall_edge;
  logic [CW-1:0] c_q;
  logic [3:0]    n_q;
  logic [8:0]    b_q;
  logic          ack_err_q;
  logic          c_low_q;
  logic          d_low_q;

  // The filtered clock only changes after eight identical raw samples, so
  // short glitches on the device clock never produce a falling edge.
  always_comb begin
    filter_d = {ps2c, filter_q[7:1]};
    f_ps2c_d = f_ps2c_q;
    if (filter_d == 8'hFF) begin
      f_ps2c_d = 1'b1;
    end else if (filter_d == 8'h00) begin
      f_ps2c_d = 1'b0;
    end
  end

  assign fall_edge = f_ps2c_q & ~f_ps2c_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filter_q <= 8'h00;
      f_ps2c_q <= 1'b0;
    end else begin
      filter_q <= filter_d;
      f_ps2c_q <= f_ps2c_d;
    end
  end

  // Transmit FSM. The line pull-down enables are registered and updated on
  // the same edge as the state change. The request-to-send low time
  // therefore equals the number of cycles spent in RTS. The data line
  // enable tracks the bit that b_q[0] will hold after each shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      c_q       <= '0;
      n_q       <= 4'd0;
      b_q       <= 9'd0;
      ack_err_q <= 1'b0;
      c_low_q   <= 1'b0;
      d_low_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          c_low_q <= 1'b0;
          d_low_q <= 1'b0;
          if (wr_ps2) begin
            b_q       <= {~^din, din};
            c_q       <= CW'(RTS_CYCLES - 1);
            ack_err_q <= 1'b0;
            c_low_q   <= 1'b1;
            state_q   <= RTS;
          end
        end
        RTS: begin
          if (c_q == '0) begin
            c_low_q <= 1'b0;
            d_low_q <= 1'b1;
            state_q <= START;
          end else begin
            c_q <= c_q - 1'b1;
          end
        end
        START: begin
          if (fall_edge) begin
            n_q     <= 4'd8;
            d_low_q <= ~b_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (fall_edge) begin
            b_q <= {1'b1, b_q[8:1]};
            if (n_q == 4'd0) begin
              d_low_q <= 1'b0;
              state_q <= STOP;
            end else begin
              d_low_q <= ~b_q[1];
              n_q     <= n_q - 1'b1;
            end
          end
        end
        STOP: begin
          if (fall_edge) begin
            ack_err_q <= ps2d;
            state_q   <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (f_ps2c_q && ps2d) begin
            state_q <= IDLE;
          end
        end
        default: begin
          c_low_q <= 1'b0;
          d_low_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ps2c = c_low_q ? 1'b0 : 1'bz;
  assign ps2d = d_low_q ? 1'b0 : 1'bz;

  assign tx_idle      = (state_q == IDLE);
  assign tx_done_tick = (state_q == WAIT_IDLE) && f_ps2c_q && ps2d;
  assign ack_err      = ack_err_q;

endmodule

// File: tb/tb_ps2_tx.sv
`timescale 1ns/1ps
// Testbench for ps2_tx: the initial block plays the PS/2 device, which
// generates the clock, samples data on rising edges and optionally ACKs.
// All expected frames are hand-computed as {stop, parity, data[7:0], start}.
module tb_ps2_tx;

  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_ps2;
  logic [7:0] din;
  wire        ps2d;
  wire        ps2c;
  logic       devC;
  logic       devD;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       ack_err;

  int   checks = 0;
  int   errors = 0;
  int   doneCount = 0;
  logic idleAtDone = 1'b1;

  pullup (ps2c);
  pullup (ps2d);
  assign ps2c = devC ? 1'b0 : 1'bz;
  assign ps2d = devD ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  ps2_tx dut (
    .clk          (clk),
    .reset        (reset),
    .wr_ps2       (wr_ps2),
    .din          (din),
    .ps2d         (ps2d),
    .ps2c         (ps2c),
    .tx_idle      (tx_idle),
    .tx_done_tick (tx_done_tick),
    .ack_err      (ack_err)
  );

  // Counts completion pulses and records tx_idle while the pulse is high.
  always @(negedge clk) begin
    if (tx_done_tick) begin
      doneCount  <= doneCount + 1;
      idleAtDone <= tx_idle;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One host transaction seen from the device side. lastClock < 11 stops
  // early, disturb pokes wr_ps2/din mid-frame, and glitch adds a short
  // low pulse on ps2c during a data bit.
  task automatic applyStimulus(input logic [7:0] data, input bit giveAck,
                               input int lastClock, input bit disturb,
                               input bit glitch, output int rtsLen,
                               output logic [10:0] frame,
                               output logic [10:0] idleBits,
                               output logic ackAtAccept);
    frame    = '0;
    idleBits = '0;
    rtsLen   = 0;
    din      = data;
    wr_ps2   = 1'b1;
    @(negedge clk);
    wr_ps2      = 1'b0;
    ackAtAccept = ack_err;
    while (ps2c === 1'b0 && rtsLen < 20000) begin
      rtsLen++;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    frame[0]    = ps2d;
    idleBits[0] = tx_idle;
    for (int k = 1; k <= lastClock; k++) begin
      if (k == 11 && giveAck) devD = 1'b1;
      devC = 1'b1;
      if (disturb && k == 3) begin
        din    = ~data;
        wr_ps2 = 1'b1;
      end
      repeat (HALF) @(negedge clk);
      devC = 1'b0;
      if (disturb && k == 3) wr_ps2 = 1'b0;
      if (k <= 10) frame[k] = ps2d;
      idleBits[k] = tx_idle;
      if (k == 11) devD = 1'b0;
      if (glitch && k == 4) begin
        repeat (10) @(negedge clk);
        devC = 1'b1;
        repeat (3) @(negedge clk);
        devC = 1'b0;
        repeat (HALF - 13) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  initial begin
    int         rtsLen;
    int         doneBefore;
    logic [10:0] frame;
    logic [10:0] idleBits;
    logic        ackAcc;

    reset  = 1'b1;
    wr_ps2 = 1'b0;
    din    = 8'h00;
    devC   = 1'b0;
    devD   = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("reset_tx_idle", 32'(tx_idle), 32'd1);
    checkOutput("reset_done", 32'(tx_done_tick), 32'd0);
    checkOutput("reset_ack_err", 32'(ack_err), 32'd0);
    checkOutput("reset_ps2c", 32'(ps2c), 32'd1);
    checkOutput("reset_ps2d", 32'(ps2d), 32'd1);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] frame 0xF4 with ACK, wr_ps2/din disturbed mid-frame");
    doneBefore = doneCount;
    applyStimulus(8'hF4, 1'b1, 11, 1'b1, 1'b0, rtsLen, frame, idleBits, ackAcc);
    checkOutput("f4_rts_len", 32'(rtsLen), 32'd8191);
    checkOutput("f4_frame", 32'(frame), 32'h5E8);
    checkOutput("f4_idle_low", 32'(idleBits), 32'h000);
    checkOutput("f4_done_once", 32'(doneCount - doneBefore), 32'd1);
    checkOutput("f4_idle_at_done", 32'(idleAtDone), 32'd0);
    checkOutput("f4_ack_err", 32'(ack_err), 32'd0);
    repeat (100) @(negedge clk);
    checkOutput("f4_no_second_txn", 32'(doneCount - doneBefore), 32'd1);
    checkOutput("f4_idle_after", 32'(tx_idle), 32'd1);
    checkOutput("f4_ps2c_released", 32'(ps2c), 32'd1);
    checkOutput("f4_ps2d_released", 32'(ps2d), 32'd1);

    $display("[TB] frame 0xFF without ACK");
    doneBefore = doneCount;
    applyStimulus(8'hFF, 1'b0, 11, 1'b0, 1'b0, rtsLen, frame, idleBits, ackAcc);
    checkOutput("ff_frame", 32'(frame), 32'h7FE);
    checkOutput("ff_ack_err", 32'(ack_err), 32'd1);
    checkOutput("ff_done_once", 32'(doneCount - doneBefore), 32'd1);
    repeat (50) @(negedge clk);

    $display("[TB] frame 0x00 with ACK clears ack_err");
    doneBefore = doneCount;
    applyStimulus(8'h00, 1'b1, 11, 1'b0, 1'b0, rtsLen, frame, idleBits, ackAcc);
    checkOutput("z_ack_cleared", 32'(ackAcc), 32'd0);
    checkOutput("z_rts_len", 32'(rtsLen), 32'd8191);
    checkOutput("z_frame", 32'(frame), 32'h600);
    checkOutput("z_ack_err", 32'(ack_err), 32'd0);
    checkOutput("z_done_once", 32'(doneCount - doneBefore), 32'd1);
    repeat (50) @(negedge clk);

    $display("[TB] reset during data after 4th bit");
    doneBefore = doneCount;
    applyStimulus(8'hA5, 1'b1, 4, 1'b0, 1'b0, rtsLen, frame, idleBits, ackAcc);
    checkOutput("rst_busy_before", 32'(tx_idle), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("rst_ps2c_released", 32'(ps2c), 32'd1);
    checkOutput("rst_ps2d_released", 32'(ps2d), 32'd1);
    checkOutput("rst_tx_idle", 32'(tx_idle), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    checkOutput("rst_no_done", 32'(doneCount - doneBefore), 32'd0);

    $display("[TB] frame 0xED after reset, with ps2c glitch");
    doneBefore = doneCount;
    applyStimulus(8'hED, 1'b1, 11, 1'b0, 1'b1, rtsLen, frame, idleBits, ackAcc);
    checkOutput("ed_rts_len", 32'(rtsLen), 32'd8191);
    checkOutput("ed_frame", 32'(frame), 32'h7DA);
    checkOutput("ed_done_once", 32'(doneCount - doneBefore), 32'd1);
    checkOutput("ed_ack_err", 32'(ack_err), 32'd0);
    repeat (50) @(negedge clk);
    checkOutput("ed_idle_after", 32'(tx_idle), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
